// File: rtl/gaussian_conv3x3_rgb.sv
// 3x3 Gaussian filter ([1 2 1; 2 4 2; 1 2 1] / 16) on an RGB window.
// A rising edge of start_conv captures the window; the filtered pixel
// leaves a 3-stage pipeline three cycles later. pix_cnt and frame_done
// track the pixel position within a frame of NUM_WINDOWS pixels.
module gaussian_conv3x3_rgb #(
  parameter int unsigned NUM_WINDOWS = 1024,
  parameter int unsigned ROUND_EN    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_conv,
  input  logic [7:0]  R_window00,
  input  logic [7:0]  R_window01,
  input  logic [7:0]  R_window02,
  input  logic [7:0]  R_window10,
  input  logic [7:0]  R_window11,
  input  logic [7:0]  R_window12,
  input  logic [7:0]  R_window20,
  input  logic [7:0]  R_window21,
  input  logic [7:0]  R_window22,
  input  logic [7:0]  G_window00,
  input  logic [7:0]  G_window01,
  input  logic [7:0]  G_window02,
  input  logic [7:0]  G_window10,
  input  logic [7:0]  G_window11,
  input  logic [7:0]  G_window12,
  input  logic [7:0]  G_window20,
  input  logic [7:0]  G_window21,
  input  logic [7:0]  G_window22,
  input  logic [7:0]  B_window00,
  input  logic [7:0]  B_window01,
  input  logic [7:0]  B_window02,
  input  logic [7:0]  B_window10,
  input  logic [7:0]  B_window11,
  input  logic [7:0]  B_window12,
  input  logic [7:0]  B_window20,
  input  logic [7:0]  B_window21,
  input  logic [7:0]  B_window22,
  output logic [23:0] dout,
  output logic        dout_valid,
  output logic [15:0] pix_cnt,
  output logic        frame_done
);

  if (NUM_WINDOWS < 1 || NUM_WINDOWS > 65535) begin : g_bad_num_windows
    $error("NUM_WINDOWS must lie in 1..65535");
  end

  localparam logic [15:0] LAST_IDX = 16'(NUM_WINDOWS - 1);
  localparam logic [12:0] RND      = (ROUND_EN != 0) ? 13'd8 : 13'd0;

  // Window regrouped as [channel][row][col]; channel 0=R, 1=G, 2=B.
  logic [2:0][2:0][2:0][7:0] win;

  assign win[0][0] = {R_window02, R_window01, R_window00};
  assign win[0][1] = {R_window12, R_window11, R_window10};
  assign win[0][2] = {R_window22, R_window21, R_window20};
  assign win[1][0] = {G_window02, G_window01, G_window00};
  assign win[1][1] = {G_window12, G_window11, G_window10};
  assign win[1][2] = {G_window22, G_window21, G_window20};
  assign win[2][0] = {B_window02, B_window01, B_window00};
  assign win[2][1] = {B_window12, B_window11, B_window10};
  assign win[2][2] = {B_window22, B_window21, B_window20};

  // Trigger detection
  logic start_d;
  logic fire;

  // Pipeline state
  logic [2:0][2:0][9:0] rowsum_q;
  logic                 valid1;
  logic [2:0][11:0]     total_q;
  logic                 valid2;

  // Combinational stage results
  logic [2:0][2:0][9:0] rowsum_d;
  logic [2:0][11:0]     total_d;
  logic [2:0][12:0]     res;

  // Frame position of the next pixel to be emitted
  logic [15:0] next_idx;

  assign fire = start_conv & ~start_d;

  // Remember the previous start_conv level so a held level fires once.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_d <= 1'b0;
    end else begin
      start_d <= start_conv;
    end
  end

  // Separable kernel: horizontal [1 2 1] per row, then vertical [1 2 1],
  // then the rounding shift; each step feeds the next pipeline register.
  always_comb begin
    rowsum_d = '0;
    total_d  = '0;
    res      = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      for (int unsigned r = 0; r < 3; r++) begin
        rowsum_d[c][r] = {2'b00, win[c][r][0]}
                       + {1'b0, win[c][r][1], 1'b0}
                       + {2'b00, win[c][r][2]};
      end
      total_d[c] = {2'b00, rowsum_q[c][0]}
                 + {1'b0, rowsum_q[c][1], 1'b0}
                 + {2'b00, rowsum_q[c][2]};
      res[c] = ({1'b0, total_q[c]} + RND) >> 4;
    end
  end

  // Stage 1: capture row sums of the window present on fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      rowsum_q <= '0;
      valid1   <= 1'b0;
    end else begin
      valid1 <= fire;
      if (fire) begin
        rowsum_q <= rowsum_d;
      end
    end
  end

  // Stage 2: weighted column sum of the three row sums.
  always_ff @(posedge clk) begin
    if (rst) begin
      total_q <= '0;
      valid2  <= 1'b0;
    end else begin
      valid2 <= valid1;
      if (valid1) begin
        total_q <= total_d;
      end
    end
  end

  // Stage 3: normalised pixel; dout holds between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= valid2;
      if (valid2) begin
        dout <= {res[0][7:0], res[1][7:0], res[2][7:0]};
      end
    end
  end

  // Frame position: label each emitted pixel and flag the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_idx   <= '0;
      pix_cnt    <= '0;
      frame_done <= 1'b0;
    end else if (valid2) begin
      pix_cnt    <= next_idx;
      frame_done <= (next_idx == LAST_IDX);
      next_idx   <= (next_idx == LAST_IDX) ? '0 : next_idx + 16'd1;
    end else begin
      frame_done <= 1'b0;
    end
  end

  // The kernel weights sum to 16, so the shifted result always fits 8 bits.
  always_ff @(posedge clk) begin
    if (!rst && valid2) begin
      for (int unsigned c = 0; c < 3; c++) begin
        assert (res[c] <= 13'd255);
      end
    end
  end

endmodule
